// File: rtl/pixel_buf_pkg.sv
// Shared types and constants for the layer pixel buffer.
package pixel_buf_pkg;

    // Frame state: filling from the producer, or holding a complete frame for the consumer.
    typedef enum logic {
        PB_FILL = 1'b0,
        PB_FULL = 1'b1
    } pb_state_e;

    localparam int unsigned PB_DATA_W  = 128;  // 8 channels x 16 bit
    localparam int unsigned PB_ADDR_W  = 16;
    localparam int unsigned PB_WIDTH   = 16;

    // Number of pixels in a square feature map of the given edge length.
    function automatic int unsigned pb_frame_size(input int unsigned width);
        return width * width;
    endfunction

    localparam int unsigned PB_FRAME_PIXELS = pb_frame_size(PB_WIDTH);

endpackage

// File: rtl/pixel_buf_ram.sv
// Single-port-write / single-port-read frame RAM with a registered read port.
// A read and write to the same address in one cycle returns the old word.
module pixel_buf_ram #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned AW     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_zero,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; rd_zero forces a zero word for out-of-range addresses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= rd_zero ? '0 : mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/layer_pixel_buffer.sv
// Feature-map store between two CNN layers: producer fills a WIDTH x WIDTH frame,
// consumer reads it and releases it with consumer_done.
// Optional feature: define PIXEL_BUF_ERR_EN to build the sticky buf_overflow detector.
module layer_pixel_buffer
    import pixel_buf_pkg::*;
#(
    parameter int unsigned WIDTH  = PB_WIDTH,
    parameter int unsigned DATA_W = PB_DATA_W,
    parameter int unsigned ADDR_W = PB_ADDR_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              save_enable,
    input  logic [ADDR_W-1:0]                 save_row,
    input  logic [ADDR_W-1:0]                 save_col,
    input  logic [DATA_W-1:0]                 save_data,
    input  logic                              read_pixel_signal,
    input  logic [ADDR_W-1:0]                 read_row_addr,
    input  logic [ADDR_W-1:0]                 read_col_addr,
    input  logic                              consumer_done,
    output logic [DATA_W-1:0]                 read_data,
    output logic                              pixel_store_done,
    output logic [$clog2(WIDTH*WIDTH):0]      fill_count,
    output logic                              buf_overflow
);

    localparam int unsigned FRAME  = pb_frame_size(WIDTH);
    localparam int unsigned RAM_AW = $clog2(FRAME);
    localparam int unsigned CNT_W  = $clog2(FRAME) + 1;

    localparam logic [ADDR_W-1:0] WIDTH_A = ADDR_W'(WIDTH);
    localparam logic [CNT_W-1:0]  FRAME_C = CNT_W'(FRAME);

    pb_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;

    logic               wr_in_range;
    logic               rd_in_range;
    logic               releasing;
    logic               wr_ok;
    logic [RAM_AW-1:0]  wr_addr;
    logic [RAM_AW-1:0]  rd_addr;

    assign wr_in_range = (save_row < WIDTH_A) && (save_col < WIDTH_A);
    assign rd_in_range = (read_row_addr < WIDTH_A) && (read_col_addr < WIDTH_A);

    // A release and a write in the same cycle lets the write start the next frame.
    assign releasing = (state_q == PB_FULL) && consumer_done;
    assign wr_ok     = save_enable && wr_in_range && ((state_q == PB_FILL) || releasing);

    assign wr_addr = RAM_AW'(save_row) * RAM_AW'(WIDTH) + RAM_AW'(save_col);
    assign rd_addr = RAM_AW'(read_row_addr) * RAM_AW'(WIDTH) + RAM_AW'(read_col_addr);

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state and fill counter update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            PB_FILL: begin
                if (wr_ok) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == FRAME_C) begin
                        state_d = PB_FULL;
                    end
                end
            end
            PB_FULL: begin
                if (consumer_done) begin
                    state_d = PB_FILL;
                    cnt_d   = wr_ok ? CNT_W'(1) : '0;
                end
            end
            default: begin
                state_d = PB_FILL;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PB_FILL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pixel_store_done = (state_q == PB_FULL);
    assign fill_count       = cnt_q;

`ifdef PIXEL_BUF_ERR_EN
    logic ovf_q;

    // Sticky flag: any write strobe that was not accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (save_enable && !wr_ok) begin
            ovf_q <= 1'b1;
        end
    end

    assign buf_overflow = ovf_q;
`else
    assign buf_overflow = 1'b0;
`endif

    pixel_buf_ram #(
        .DEPTH  (FRAME),
        .DATA_W (DATA_W),
        .AW     (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok),
        .wr_addr (wr_addr),
        .wr_data (save_data),
        .rd_en   (read_pixel_signal),
        .rd_zero (!rd_in_range),
        .rd_addr (rd_addr),
        .rd_data (read_data)
    );

endmodule

// File: tb/tb_layer_pixel_buffer.sv
// Self-checking bench for layer_pixel_buffer: directed scenarios plus random traffic
// compared against a frame-level reference model.
module tb_layer_pixel_buffer;

    localparam int WIDTH  = 16;
    localparam int DATA_W = 128;
    localparam int ADDR_W = 16;
    localparam int FRAME  = WIDTH * WIDTH;
    localparam int CNT_W  = $clog2(FRAME) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              save_enable;
    logic [ADDR_W-1:0] save_row, save_col;
    logic [DATA_W-1:0] save_data;
    logic              read_pixel_signal;
    logic [ADDR_W-1:0] read_row_addr, read_col_addr;
    logic              consumer_done;
    logic [DATA_W-1:0] read_data;
    logic              pixel_store_done;
    logic [CNT_W-1:0]  fill_count;
    logic              buf_overflow;

    layer_pixel_buffer #(
        .WIDTH  (WIDTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .save_enable       (save_enable),
        .save_row          (save_row),
        .save_col          (save_col),
        .save_data         (save_data),
        .read_pixel_signal (read_pixel_signal),
        .read_row_addr     (read_row_addr),
        .read_col_addr     (read_col_addr),
        .consumer_done     (consumer_done),
        .read_data         (read_data),
        .pixel_store_done  (pixel_store_done),
        .fill_count        (fill_count),
        .buf_overflow      (buf_overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: stored pixels, frame occupancy, last read word.
    logic [DATA_W-1:0] m_mem   [FRAME];
    bit                m_valid [FRAME];
    logic [DATA_W-1:0] m_rd;
    bit                m_rd_known;
    bit                m_full;
    int                m_cnt;
    bit                m_ovf;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pix(input int r, input int c);
        logic [15:0] v;
        v = 16'(r * 16 + c);
        return {8{v}};
    endfunction

    function automatic logic [DATA_W-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Apply the effect of one clock edge to the model, using the inputs held over the edge.
    task automatic model_edge();
        int  r, c, wr, wc;
        bit  accept;
        r  = int'(read_row_addr);
        c  = int'(read_col_addr);
        wr = int'(save_row);
        wc = int'(save_col);
        if (read_pixel_signal) begin
            if (r >= WIDTH || c >= WIDTH) begin
                m_rd       = '0;
                m_rd_known = 1'b1;
            end else begin
                m_rd       = m_mem[r * WIDTH + c];
                m_rd_known = m_valid[r * WIDTH + c];
            end
        end
        accept = save_enable && wr < WIDTH && wc < WIDTH && (!m_full || consumer_done);
        if (m_full && consumer_done) begin
            m_full = 1'b0;
            m_cnt  = 0;
        end
        if (accept) begin
            m_mem[wr * WIDTH + wc]   = save_data;
            m_valid[wr * WIDTH + wc] = 1'b1;
            m_cnt++;
            if (m_cnt == FRAME) m_full = 1'b1;
        end
        if (save_enable && !accept) m_ovf = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        logic exp_ovf;
`ifdef PIXEL_BUF_ERR_EN
        exp_ovf = m_ovf;
`else
        exp_ovf = 1'b0;
`endif
        check({tag, ".done"}, DATA_W'(pixel_store_done), DATA_W'(m_full));
        check({tag, ".fill"}, DATA_W'(fill_count), DATA_W'(m_cnt));
        check({tag, ".ovf"}, DATA_W'(buf_overflow), DATA_W'(exp_ovf));
        if (m_rd_known) check({tag, ".rdata"}, read_data, m_rd);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        save_enable       = 1'b0;
        save_row          = '0;
        save_col          = '0;
        save_data         = '0;
        read_pixel_signal = 1'b0;
        read_row_addr     = '0;
        read_col_addr     = '0;
        consumer_done     = 1'b0;
    endtask

    task automatic set_write(input int r, input int c, input logic [DATA_W-1:0] d);
        save_enable = 1'b1;
        save_row    = ADDR_W'(r);
        save_col    = ADDR_W'(c);
        save_data   = d;
    endtask

    task automatic set_read(input int r, input int c);
        read_pixel_signal = 1'b1;
        read_row_addr     = ADDR_W'(r);
        read_col_addr     = ADDR_W'(c);
    endtask

    // Assert reset away from a clock edge and check outputs clear immediately.
    task automatic apply_reset(input string tag);
        rst = 1'b0;
        #1;
        m_full     = 1'b0;
        m_cnt      = 0;
        m_ovf      = 1'b0;
        m_rd       = '0;
        m_rd_known = 1'b1;
        check_outputs(tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic raster_fill(input string tag, input int upto);
        for (int i = 0; i < upto; i++) begin
            set_write(i / WIDTH, i % WIDTH, pix(i / WIDTH, i % WIDTH));
            cycle(tag);
        end
        idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < FRAME; i++) m_valid[i] = 1'b0;
        idle_inputs();
        rst = 1'b1;
        #2;
        apply_reset("reset");

        // Raster fill; done must be low right up to the 256th write edge.
        for (int i = 0; i < FRAME; i++) begin
            set_write(i / WIDTH, i % WIDTH, pix(i / WIDTH, i % WIDTH));
            cycle("fill");
            if (i == FRAME - 2) check("fill.done_before_last", DATA_W'(pixel_store_done), '0);
        end
        idle_inputs();
        check("fill.done_after_last", DATA_W'(pixel_store_done), DATA_W'(1));
        check("fill.count_256", DATA_W'(fill_count), DATA_W'(256));

        // Read (3,5), then hold with strobe low.
        set_read(3, 5);
        cycle("rd35");
        check("rd35.value", read_data, {8{16'd53}});
        idle_inputs();
        for (int i = 0; i < 3; i++) cycle("rd_hold");
        check("rd_hold.value", read_data, {8{16'd53}});

        // Write while full is dropped.
        set_write(0, 0, {DATA_W{1'b1}});
        cycle("full_wr");
        idle_inputs();
        set_read(0, 0);
        cycle("full_wr_rd");
        check("full_wr_rd.value", read_data, {8{16'd0}});
        idle_inputs();

        // Release with a simultaneous first write of the next frame.
        consumer_done = 1'b1;
        set_write(0, 0, {8{16'hA5A5}});
        cycle("release");
        idle_inputs();
        check("release.done", DATA_W'(pixel_store_done), '0);
        check("release.count", DATA_W'(fill_count), DATA_W'(1));
        set_read(0, 0);
        cycle("release_rd");
        check("release_rd.value", read_data, {8{16'hA5A5}});
        idle_inputs();

        // Out-of-range write and read.
        set_write(16, 2, {8{16'h1234}});
        set_read(2, 16);
        cycle("oor");
        idle_inputs();
        check("oor.rdata", read_data, '0);
        check("oor.count", DATA_W'(fill_count), DATA_W'(1));

        // Consumer_done while filling is ignored.
        consumer_done = 1'b1;
        cycle("cd_in_fill");
        idle_inputs();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            idle_inputs();
            if ($urandom_range(0, 9) < 8) begin
                set_write($urandom_range(0, 16), $urandom_range(0, 16), rand_word());
            end
            if ($urandom_range(0, 1) == 1) begin
                set_read($urandom_range(0, 16), $urandom_range(0, 16));
            end
            if ($urandom_range(0, 31) == 0) consumer_done = 1'b1;
            cycle("rand");
        end
        idle_inputs();

        // Reset mid-frame after 100 writes, then a full frame from scratch.
        apply_reset("rst_pre");
        raster_fill("pre_rst", 100);
        apply_reset("rst_mid");
        raster_fill("refill", FRAME - 1);
        check("refill.done_at_255", DATA_W'(pixel_store_done), '0);
        set_write(WIDTH - 1, WIDTH - 1, pix(WIDTH - 1, WIDTH - 1));
        cycle("refill_last");
        idle_inputs();
        check("refill.done_at_256", DATA_W'(pixel_store_done), DATA_W'(1));
        set_read(WIDTH - 1, WIDTH - 1);
        cycle("refill_rd");
        check("refill_rd.value", read_data, pix(WIDTH - 1, WIDTH - 1));
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
